usr_shift_engine: RTL and testbench
===================================

Name: usr_shift_engine

Overview:
Parametrised universal shift register, successor to the 4-bit universal shift register. Generalised to WIDTH bits. Adds rotate, arithmetic shift, synchronous clear, registered serial outputs, and a counted multi-step "burst" mode with a busy/done handshake. It is the datapath shifter for serialiser and multiplier blocks in the same design.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_W, $clog2(WIDTH)+1, width of burst step count (localparam-derivable; amt up to 2^AMT_W-1)

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  asynchronous, active-low reset
en  in  1  step enable; 0 stalls all register/FSM updates except reset
start  in  1  burst request, sampled only in IDLE
op  in  3  operation select (see Behaviour)
amt  in  AMT_W  burst step count, sampled with accepted start
sinr  in  1  serial input into MSB on right shift
sinl  in  1  serial input into bit 0 on left shift
inp  in  WIDTH  parallel load data
pout  out  WIDTH  register contents
soutr  out  1  last bit shifted out of bit 0 (registered)
soutl  out  1  last bit shifted out of MSB (registered)
busy  out  1  burst in progress
done  out  1  one-cycle burst completion pulse

Behaviour:
- Reset (clr=0, async, any state): pout=0, soutr=0, soutl=0, busy=0, done=0, FSM=IDLE, counter=0.
- op encoding (one "step"):
  - 000 hold
  - 001 shift right: pout <= {sinr, pout[W-1:1]}, soutr <= pout[0]
  - 010 shift left: pout <= {pout[W-2:0], sinl}, soutl <= pout[W-1]
  - 011 parallel load: pout <= inp
  - 100 rotate right: pout <= {pout[0], pout[W-1:1]}, soutr <= pout[0]
  - 101 rotate left: pout <= {pout[W-2:0], pout[W-1]}, soutl <= pout[W-1]
  - 110 arithmetic shift right: pout <= {pout[W-1], pout[W-1:1]}, soutr <= pout[0]
  - 111 synchronous clear: pout <= 0
- soutr/soutl change only on the step types listed above; otherwise they hold.
- FSM states: IDLE, RUN. done is a registered output, default 0 every cycle unless set below.
- IDLE, en=1, start=0: apply op as a single step each cycle (free-running mode).
- IDLE, en=1, start=1:
  - op in {001,010,100,101,110} with amt>0: no step this edge; latch op, load counter=amt; go to RUN; busy=1.
  - amt=0, or op in {000,011,111}: execute op once (000 = no change) on this edge; stay IDLE; done=1 next cycle; busy stays 0.
- RUN, en=1: perform one step with the latched op on each edge (sinr/sinl sampled live) and decrement the counter. On the edge where the counter is 1: go to IDLE, busy=0, done=1 for the following cycle.
- Result: burst of amt=k accepted at edge T0 gives busy high for exactly k cycles, final pout after edge T0+k, done high for the single cycle after T0+k.
- RUN: op, amt and start inputs are ignored; start while busy is dropped (not queued).
- en=0 in any state: pout, souts, counter and FSM hold; done deasserts; busy holds.
- amt > WIDTH is legal: steps execute literally (e.g. shift right by WIDTH+1 with sinr=0 gives 0).
- Reset mid-burst aborts immediately: no done pulse.

Test Plan:
- Reset: drive clr=0 with random inputs -> pout=8'h00, soutr=soutl=busy=done=0, asynchronously (before next clk edge).
- Free-run: op=011 inp=8'hA5, then op=001 sinr=1 for one cycle -> pout=8'hD2, soutr=1, soutl=0.
- Burst rotate left: pout=8'h81, start op=101 amt=3 -> busy high for 3 cycles, pout 03/06/0C, final 8'h0C, soutl=0, done high one cycle after last step.
- Burst arithmetic right: pout=8'h90, start op=110 amt=2 -> pout 8'hC8 then 8'hE4, soutr=0; start pulsed while busy ignored (no extra steps, no second done).
- Stall: same burst as rotate-left scenario, en=0 for 2 cycles mid-run -> busy lasts 5 cycles, final 8'h0C, exactly one done pulse.
- Abort and zero-count: clr low during RUN -> all zero, busy=0, no done. Then start op=001 amt=0 -> pout unchanged, busy stays 0, done pulses once.

Source files
------------

// File: rtl/usr_shift_engine_if.sv
// Handshake and data bundle for usr_shift_engine.
// The master side drives the step controls and data; the slave side is the shifter.
interface usr_shift_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             sinr;
    logic             sinl;
    logic [WIDTH-1:0] inp;
    logic [WIDTH-1:0] pout;
    logic             soutr;
    logic             soutl;
    logic             busy;
    logic             done;

    modport master (
        output en, start, op, amt, sinr, sinl, inp,
        input  pout, soutr, soutl, busy, done
    );

    modport slave (
        input  en, start, op, amt, sinr, sinl, inp,
        output pout, soutr, soutl, busy, done
    );
endinterface

// File: rtl/usr_shift_engine.sv
// Parametrised universal shift register with shift/rotate/arithmetic/load/clear
// steps, registered serial outputs and a counted burst mode with busy/done.
module usr_shift_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    usr_shift_engine_if.slave  bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pout_q;
    logic             soutr_q;
    logic             soutl_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       step_op_c;
    logic [WIDTH-1:0] pout_d;
    logic             soutr_d;
    logic             soutl_d;
    logic             burst_op_c;

    // Result of one step with the live op in IDLE or the latched op in RUN.
    always_comb begin
        step_op_c = (state_q == RUN) ? op_q : bus.op;
        pout_d    = pout_q;
        soutr_d   = soutr_q;
        soutl_d   = soutl_q;
        case (step_op_c)
            OP_SHR: begin
                pout_d  = {bus.sinr, pout_q[WIDTH-1:1]};
                soutr_d = pout_q[0];
            end
            OP_SHL: begin
                pout_d  = {pout_q[WIDTH-2:0], bus.sinl};
                soutl_d = pout_q[WIDTH-1];
            end
            OP_LOAD: pout_d = bus.inp;
            OP_ROR: begin
                pout_d  = {pout_q[0], pout_q[WIDTH-1:1]};
                soutr_d = pout_q[0];
            end
            OP_ROL: begin
                pout_d  = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
                soutl_d = pout_q[WIDTH-1];
            end
            OP_ASR: begin
                pout_d  = {pout_q[WIDTH-1], pout_q[WIDTH-1:1]};
                soutr_d = pout_q[0];
            end
            OP_CLR:  pout_d = '0;
            default: pout_d = pout_q;
        endcase
    end

    // Ops that may run as a counted burst; hold/load/clear always act once.
    always_comb begin
        burst_op_c = (bus.op == OP_SHR) || (bus.op == OP_SHL) ||
                     (bus.op == OP_ROR) || (bus.op == OP_ROL) ||
                     (bus.op == OP_ASR);
    end

    // Burst FSM, step counter and registered datapath outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            pout_q  <= '0;
            soutr_q <= 1'b0;
            soutl_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.en) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && burst_op_c && (bus.amt != '0)) begin
                        op_q    <= bus.op;
                        cnt_q   <= bus.amt;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        pout_q  <= pout_d;
                        soutr_q <= soutr_d;
                        soutl_q <= soutl_d;
                        done_q  <= bus.start;
                    end
                end
                RUN: begin
                    pout_q  <= pout_d;
                    soutr_q <= soutr_d;
                    soutl_q <= soutl_d;
                    cnt_q   <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.pout  = pout_q;
    assign bus.soutr = soutr_q;
    assign bus.soutl = soutl_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_usr_shift_engine.sv
// Self-checking bench for usr_shift_engine: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_usr_shift_engine;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state.
    logic [W-1:0] m_pout = '0;
    logic         m_sr   = 1'b0;
    logic         m_sl   = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [2:0]   m_op   = 3'd0;

    usr_shift_engine_if #(.WIDTH(W)) bus ();

    usr_shift_engine #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {bus.pout, bus.soutr, bus.soutl, bus.busy, bus.done};
    endfunction

    task automatic model_reset();
        m_pout = '0; m_sr = 1'b0; m_sl = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_op = 3'd0;
    endtask

    // One register step expressed as plain arithmetic on the value.
    task automatic model_apply(input logic [2:0] o);
        case (o)
            3'd1: begin m_sr = m_pout[0]; m_pout = (m_pout >> 1) | (bus.sinr ? 8'h80 : 8'h00); end
            3'd2: begin m_sl = m_pout[7]; m_pout = (m_pout << 1) | {7'd0, bus.sinl}; end
            3'd3: m_pout = bus.inp;
            3'd4: begin m_sr = m_pout[0]; m_pout = (m_pout >> 1) | (m_pout[0] ? 8'h80 : 8'h00); end
            3'd5: begin m_sl = m_pout[7]; m_pout = (m_pout << 1) | {7'd0, m_pout[7]}; end
            3'd6: begin m_sr = m_pout[0]; m_pout = (m_pout >> 1) | (m_pout & 8'h80); end
            3'd7: m_pout = '0;
            default: ;
        endcase
    endtask

    // Model of what one rising edge does given the inputs present now.
    task automatic model_edge();
        if (!clr) begin model_reset(); return; end
        m_done = 1'b0;
        if (!bus.en) return;
        if (m_busy) begin
            model_apply(m_op);
            m_left = m_left - 1;
            if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end else if (bus.start && bus.amt != 0 &&
                     (bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd4 ||
                      bus.op == 3'd5 || bus.op == 3'd6)) begin
            m_op = bus.op; m_left = int'(bus.amt); m_busy = 1'b1;
        end else begin
            model_apply(bus.op);
            if (bus.start) m_done = 1'b1;
        end
    endtask

    task automatic adv();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'hFF;
        bus.amt = '0; bus.sinr = 1'b0; bus.sinl = 1'b0;
        adv();
        bus.en = 1'($urandom); bus.start = 1'($urandom); bus.op = 3'($urandom);
        bus.amt = AW'($urandom); bus.sinr = 1'($urandom); bus.sinl = 1'($urandom);
        bus.inp = 8'($urandom);
        #1 clr = 1'b0;
        #1;
        model_reset();
        checks++;
        if (observed() !== 12'h000) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", observed(), 12'h000);
        end
        adv();
        checks++;
        if (observed() !== 12'h000) begin
            failures++;
            $display("FAIL reset_held: got %h expected %h", observed(), 12'h000);
        end
        clr = 1'b1;
    endtask

    task automatic test_free_run();
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'hA5;
        adv();
        checks++;
        if (bus.pout !== 8'hA5) begin
            failures++;
            $display("FAIL free_load: got %h expected %h", bus.pout, 8'hA5);
        end
        bus.op = 3'd1; bus.sinr = 1'b1; bus.sinl = 1'b0;
        adv();
        checks++;
        if (observed() !== {8'hD2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL free_shr: got %h expected %h", observed(), {8'hD2, 4'b1000});
        end
    endtask

    task automatic test_burst_rotl();
        logic [W-1:0] ep [3];
        logic         eb [3];
        logic         ed [3];
        ep = '{8'h03, 8'h06, 8'h0C};
        eb = '{1'b1, 1'b1, 1'b0};
        ed = '{1'b0, 1'b0, 1'b1};
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'h81;
        adv();
        bus.start = 1'b1; bus.op = 3'd5; bus.amt = AW'(3);
        adv();
        checks++;
        if ({bus.pout, bus.busy, bus.done} !== {8'h81, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rotl_accept: got %h/%b/%b expected 81/1/0", bus.pout, bus.busy, bus.done);
        end
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b0; bus.op = 3'($urandom); bus.amt = AW'($urandom);
            adv();
            checks++;
            if ({bus.pout, bus.busy, bus.done} !== {ep[i], eb[i], ed[i]}) begin
                failures++;
                $display("FAIL rotl_step%0d: got %h/%b/%b expected %h/%b/%b",
                         i, bus.pout, bus.busy, bus.done, ep[i], eb[i], ed[i]);
            end
        end
        bus.op = 3'd0;
        adv();
        checks++;
        if ({bus.pout, bus.soutl, bus.busy, bus.done} !== {8'h0C, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rotl_after: got %h/%b/%b/%b expected 0c/0/0/0",
                     bus.pout, bus.soutl, bus.busy, bus.done);
        end
    endtask

    task automatic test_burst_asr();
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'h90;
        adv();
        bus.start = 1'b1; bus.op = 3'd6; bus.amt = AW'(2);
        adv();
        bus.start = 1'b1; bus.op = 3'($urandom); bus.amt = AW'($urandom);
        adv();
        checks++;
        if ({bus.pout, bus.soutr, bus.busy, bus.done} !== {8'hC8, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL asr_step0: got %h/%b/%b/%b expected c8/0/1/0",
                     bus.pout, bus.soutr, bus.busy, bus.done);
        end
        bus.start = 1'b0;
        adv();
        checks++;
        if ({bus.pout, bus.soutr, bus.busy, bus.done} !== {8'hE4, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL asr_step1: got %h/%b/%b/%b expected e4/0/0/1",
                     bus.pout, bus.soutr, bus.busy, bus.done);
        end
        bus.op = 3'd0;
        adv();
        adv();
        checks++;
        if ({bus.pout, bus.busy, bus.done} !== {8'hE4, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL asr_no_extra: got %h/%b/%b expected e4/0/0", bus.pout, bus.busy, bus.done);
        end
    endtask

    task automatic test_stall();
        logic         en_seq [5];
        logic [W-1:0] ep [5];
        int           busy_cnt;
        int           done_cnt;
        en_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ep     = '{8'h03, 8'h03, 8'h03, 8'h06, 8'h0C};
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'h81;
        adv();
        bus.start = 1'b1; bus.op = 3'd5; bus.amt = AW'(3);
        adv();
        busy_cnt = int'(bus.busy);
        done_cnt = int'(bus.done);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.en = en_seq[i];
            adv();
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            checks++;
            if (bus.pout !== ep[i]) begin
                failures++;
                $display("FAIL stall_pout%0d: got %h expected %h", i, bus.pout, ep[i]);
            end
        end
        bus.en = 1'b1; bus.op = 3'd0;
        adv();
        done_cnt += int'(bus.done);
        checks++;
        if (busy_cnt != 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_counts: got busy=%0d done=%0d expected busy=5 done=1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_abort_zero();
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'h3C;
        adv();
        bus.start = 1'b1; bus.op = 3'd1; bus.amt = AW'(5); bus.sinr = 1'b1;
        adv();
        bus.start = 1'b0;
        adv();
        #1 clr = 1'b0;
        #1;
        model_reset();
        checks++;
        if (observed() !== 12'h000) begin
            failures++;
            $display("FAIL abort_async: got %h expected %h", observed(), 12'h000);
        end
        adv();
        clr = 1'b1; bus.op = 3'd0;
        adv();
        checks++;
        if (observed() !== 12'h000) begin
            failures++;
            $display("FAIL abort_no_done: got %h expected %h", observed(), 12'h000);
        end
        bus.start = 1'b1; bus.op = 3'd1; bus.amt = '0; bus.sinr = 1'b0;
        adv();
        checks++;
        if (observed() !== 12'h001) begin
            failures++;
            $display("FAIL zero_count: got %h expected %h", observed(), 12'h001);
        end
        bus.start = 1'b0; bus.op = 3'd0;
        adv();
        checks++;
        if (observed() !== 12'h000) begin
            failures++;
            $display("FAIL zero_count_pulse: got %h expected %h", observed(), 12'h000);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ev [5];
        ev = '{{8'h01, 4'b0010}, {8'h02, 4'b0010}, {8'h04, 4'b0001},
               {8'h04, 4'b0010}, {8'h02, 4'b0001}};
        bus.en = 1'b1; bus.start = 1'b0; bus.op = 3'd3; bus.inp = 8'h01;
        bus.sinr = 1'b0; bus.sinl = 1'b0;
        adv();
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 0 || i == 3);
            bus.op    = (i == 3) ? 3'd1 : 3'd2;
            bus.amt   = (i == 3) ? AW'(1) : AW'(2);
            adv();
            checks++;
            if (observed() !== ev[i]) begin
                failures++;
                $display("FAIL b2b_%0d: got %h expected %h", i, observed(), ev[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.en    = ($urandom % 8) != 0;
            bus.start = ($urandom % 4) == 0;
            bus.op    = 3'($urandom);
            bus.amt   = AW'($urandom);
            bus.sinr  = 1'($urandom);
            bus.sinl  = 1'($urandom);
            bus.inp   = 8'($urandom);
            adv();
            checks++;
            if (observed() !== {m_pout, m_sr, m_sl, m_busy, m_done}) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h",
                         n, observed(), {m_pout, m_sr, m_sl, m_busy, m_done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_burst_rotl();
        test_burst_asr();
        test_stall();
        test_abort_zero();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
